// File: rtl/alarm_ctrl.sv
// Alarm sequencer: detects the alarm minute edge and runs the IDLE/ARMED/RINGING/SNOOZE machine.
// Outputs are decoded from registered state and the ring tick counter.
module alarm_ctrl #(
  parameter int unsigned CLOCK_FREQUENCY  = 27_000_000,
  parameter int unsigned SNOOZE_MIN       = 5,
  parameter int unsigned RING_TIMEOUT_MIN = 10,
  parameter int unsigned MAX_SNOOZE       = 3
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [19:0] i_time,
  input  logic [19:0] i_alarm_time,
  input  logic        i_alarm_en,
  input  logic        i_btn_snooze,
  input  logic        i_btn_stop,
  output logic [1:0]  o_alarm_state,
  output logic        o_ringing,
  output logic        o_snooze_active,
  output logic        o_buzzer
);

  localparam int unsigned TICK_W   = $clog2(CLOCK_FREQUENCY);
  localparam int unsigned MAX_MIN  = (RING_TIMEOUT_MIN > SNOOZE_MIN) ? RING_TIMEOUT_MIN : SNOOZE_MIN;
  localparam int unsigned SEC_W    = $clog2(MAX_MIN * 60 + 1);
  localparam int unsigned SNZ_W    = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;
  localparam int unsigned RING_SEC = RING_TIMEOUT_MIN * 60;
  localparam int unsigned SNZ_SEC  = SNOOZE_MIN * 60;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_RINGING = 2'd2,
    ST_SNOOZE  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [TICK_W-1:0]  tick_q, tick_d;
  logic [SEC_W-1:0]   sec_q, sec_d;
  logic [SNZ_W-1:0]   snooze_q, snooze_d;
  logic               match_q;

  logic match_now, trigger, tick_wrap, ring_done, snz_done, counting;
  logic unused_alarm_sec;

  // Seconds field of the alarm time is don't-care
  assign unused_alarm_sec = ^i_alarm_time[6:0];

  assign match_now = (i_time[19:7] == i_alarm_time[19:7]) && (i_time[6:0] == 7'd0);
  assign trigger   = match_now & ~match_q;
  assign tick_wrap = (tick_q == TICK_W'(CLOCK_FREQUENCY - 1));
  // Timeouts fire on the wrap that would bring sec_cnt up to the limit
  assign ring_done = tick_wrap && (sec_q == SEC_W'(RING_SEC - 1));
  assign snz_done  = tick_wrap && (sec_q == SEC_W'(SNZ_SEC - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      tick_q   <= '0;
      sec_q    <= '0;
      snooze_q <= '0;
      match_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      sec_q    <= sec_d;
      snooze_q <= snooze_d;
      match_q  <= match_now;
    end
  end

  always_comb begin
    state_d  = state_q;
    snooze_d = snooze_q;
    tick_d   = '0;
    sec_d    = '0;
    counting = 1'b0;

    if (!i_alarm_en) begin
      state_d  = ST_IDLE;
      snooze_d = '0;
    end else begin
      case (state_q)
        ST_IDLE:  state_d = ST_ARMED;
        ST_ARMED: if (trigger) state_d = ST_RINGING;
        ST_RINGING: begin
          if (i_btn_stop) begin
            state_d = ST_ARMED;
          end else if (i_btn_snooze && (snooze_q < SNZ_W'(MAX_SNOOZE))) begin
            state_d  = ST_SNOOZE;
            snooze_d = snooze_q + SNZ_W'(1);
          end else if (ring_done) begin
            state_d = ST_ARMED;
          end
        end
        ST_SNOOZE: begin
          if (i_btn_stop) begin
            state_d = ST_ARMED;
          end else if (snz_done) begin
            state_d = ST_RINGING;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (state_d == ST_ARMED) snooze_d = '0;

    // Counters run only while staying in RINGING/SNOOZE; any entry restarts them
    counting = (state_d == state_q) && ((state_q == ST_RINGING) || (state_q == ST_SNOOZE));
    if (counting) begin
      if (tick_wrap) begin
        tick_d = '0;
        sec_d  = sec_q + SEC_W'(1);
      end else begin
        tick_d = tick_q + TICK_W'(1);
        sec_d  = sec_q;
      end
    end
  end

  assign o_alarm_state   = state_q;
  assign o_ringing       = (state_q == ST_RINGING);
  assign o_snooze_active = (state_q == ST_SNOOZE);
  assign o_buzzer        = (state_q == ST_RINGING) && (tick_q < TICK_W'(CLOCK_FREQUENCY / 2));

endmodule

// File: tb/tb_alarm_ctrl.sv
// Bench for alarm_ctrl: directed scenarios with literal expectations, then random stimulus
// checked every cycle against a cycle-count model driven by decoded wall-clock minutes.
module tb_alarm_ctrl;

  localparam int CF       = 4;
  localparam int SNZ_MIN  = 1;
  localparam int RING_MIN = 2;
  localparam int MAXS     = 2;
  localparam int RING_CYC = RING_MIN * 60 * CF;
  localparam int SNZ_CYC  = SNZ_MIN * 60 * CF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [19:0] tm = 20'h0;
  logic [19:0] alarm = 20'h1D855;
  logic        en = 1'b0;
  logic        snooze = 1'b0;
  logic        stop = 1'b0;
  logic [1:0]  o_state;
  logic        o_ringing, o_snz, o_buzzer;

  int checks = 0;
  int errors = 0;

  alarm_ctrl #(
    .CLOCK_FREQUENCY(CF), .SNOOZE_MIN(SNZ_MIN),
    .RING_TIMEOUT_MIN(RING_MIN), .MAX_SNOOZE(MAXS)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_time(tm), .i_alarm_time(alarm),
    .i_alarm_en(en), .i_btn_snooze(snooze), .i_btn_stop(stop),
    .o_alarm_state(o_state), .o_ringing(o_ringing),
    .o_snooze_active(o_snz), .o_buzzer(o_buzzer)
  );

  always #5 clk = ~clk;

  function automatic logic [19:0] enc(int h, int m, int s);
    return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10)};
  endfunction

  function automatic int minute_of(logic [19:0] t);
    int hh, mm;
    hh = 10 * int'(t[19:18]) + int'(t[17:14]);
    mm = 10 * int'(t[13:11]) + int'(t[10:7]);
    return hh * 60 + mm;
  endfunction

  function automatic int second_of(logic [19:0] t);
    return 10 * int'(t[6:4]) + int'(t[3:0]);
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: mode 0..3, cycles spent since entering RINGING/SNOOZE, snoozes used this event
  int m_state = 0, m_elapsed = 0, m_snz = 0, m_ns = 0;
  bit m_prev = 1'b1, m_now, m_trig;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state = 0; m_elapsed = 0; m_snz = 0; m_prev = 1'b1;
    end else begin
      m_now  = (minute_of(tm) == minute_of(alarm)) && (second_of(tm) == 0);
      m_trig = m_now && !m_prev;
      m_ns   = m_state;
      if (!en) begin
        m_ns = 0; m_snz = 0;
      end else if (m_state == 0) begin
        m_ns = 1;
      end else if (m_state == 1) begin
        if (m_trig) m_ns = 2;
      end else if (m_state == 2) begin
        if (stop) m_ns = 1;
        else if (snooze && m_snz < MAXS) begin m_ns = 3; m_snz++; end
        else if (m_elapsed + 1 == RING_CYC) m_ns = 1;
      end else begin
        if (stop) m_ns = 1;
        else if (m_elapsed + 1 == SNZ_CYC) m_ns = 2;
      end
      if (m_ns == 1) m_snz = 0;
      if (m_ns != m_state || m_ns < 2) m_elapsed = 0;
      else m_elapsed++;
      m_state = m_ns;
      m_prev  = m_now;
    end
  end

  always @(negedge clk) begin
    chk("model_state", int'(o_state), m_state);
    chk("model_ringing", int'(o_ringing), int'(m_state == 2));
    chk("model_snooze", int'(o_snz), int'(m_state == 3));
    chk("model_buzzer", int'(o_buzzer), int'(m_state == 2 && (m_elapsed % CF) < CF / 2));
  end

  task automatic cyc(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Fresh 0->1 match edge: one cycle at 07:29:59, then 07:30:00
  task automatic ring_now();
    tm = enc(7, 29, 59); cyc();
    tm = enc(7, 30, 0);  cyc();
  endtask

  task automatic count_while(int st, output int n);
    n = 0;
    while (int'(o_state) == st && n < 2000) begin cyc(); n++; end
  endtask

  int n;
  int pat [4] = '{1, 1, 0, 0};
  int hold, ah, am, tmin;

  initial begin
    // Reset, with 07:30:00 present and enable high at release
    #1 rst_n = 1'b0; tm = enc(7, 30, 0); en = 1'b1;
    #2;
    chk("reset_state", int'(o_state), 0);
    chk("reset_outputs", int'({o_ringing, o_snz, o_buzzer}), 0);
    cyc(3);
    rst_n = 1'b1;
    cyc(10);
    chk("no_ring_at_reset_release", int'(o_state), 1);

    // Basic ring and buzzer cadence
    ring_now();
    chk("ring_on_match", int'(o_state), 2);
    for (int k = 0; k < 8; k++) begin
      chk("buzzer_cadence", int'(o_buzzer), pat[k % 4]);
      cyc();
    end

    // Stop inside the matching second
    stop = 1'b1; cyc(); stop = 1'b0;
    chk("stop_to_armed", int'(o_state), 1);
    chk("stop_buzzer_off", int'(o_buzzer), 0);
    cyc(20);
    chk("no_retrigger_same_second", int'(o_state), 1);

    // Auto-silence
    ring_now();
    count_while(2, n);
    chk("ring_timeout_cycles", n, 480);
    chk("timeout_to_armed", int'(o_state), 1);
    chk("timeout_buzzer_off", int'(o_buzzer), 0);

    // Snooze twice, third snooze ignored
    ring_now();
    for (int s = 0; s < 2; s++) begin
      snooze = 1'b1; cyc(); snooze = 1'b0;
      chk("snooze_entry", int'(o_state), 3);
      chk("snooze_flag", int'(o_snz), 1);
      count_while(3, n);
      chk("snooze_length_cycles", n, 240);
      chk("snooze_back_to_ring", int'(o_state), 2);
    end
    snooze = 1'b1; cyc(); snooze = 1'b0;
    chk("third_snooze_ignored", int'(o_state), 2);
    stop = 1'b1; cyc(); stop = 1'b0;

    // Stop and snooze together
    ring_now();
    stop = 1'b1; snooze = 1'b1; cyc(); stop = 1'b0; snooze = 1'b0;
    chk("stop_beats_snooze", int'(o_state), 1);

    // Disable while ringing
    ring_now();
    en = 1'b0; cyc();
    chk("disable_to_idle", int'(o_state), 0);
    en = 1'b1; cyc();
    chk("reenable_armed", int'(o_state), 1);

    // Async reset while snoozing
    ring_now();
    snooze = 1'b1; cyc(); snooze = 1'b0;
    chk("snooze_before_reset", int'(o_state), 3);
    rst_n = 1'b0; #1;
    chk("async_reset_state", int'(o_state), 0);
    chk("async_reset_outputs", int'({o_ringing, o_snz, o_buzzer}), 0);
    cyc(2); rst_n = 1'b1; cyc(2);

    // Time jumps past the match second
    tm = enc(7, 29, 59); cyc();
    tm = enc(7, 30, 5);  cyc(5);
    chk("skip_match_second", int'(o_state), 1);

    // Match while disabled, then re-enable inside the match second
    en = 1'b0; tm = enc(7, 29, 59); cyc();
    tm = enc(7, 30, 0); cyc();
    en = 1'b1; cyc(6);
    chk("match_while_disabled", int'(o_state), 1);

    // Random phase against the model
    ah = 7; am = 30; hold = 1;
    for (int c = 0; c < 6000; c++) begin
      stop   = ($urandom_range(0, 59) == 0);
      snooze = ($urandom_range(0, 29) == 0);
      en     = ($urandom_range(0, 149) != 0);
      rst_n  = ($urandom_range(0, 2499) != 0);
      if ($urandom_range(0, 999) == 0) begin
        ah = $urandom_range(0, 23); am = $urandom_range(0, 59);
        alarm = enc(ah, am, 0) | 20'($urandom_range(0, 127));
      end
      hold--;
      if (hold == 0) begin
        hold = $urandom_range(1, 12);
        tmin = ah * 60 + am;
        case ($urandom_range(0, 5))
          0, 1: tm = enc(((tmin + 1439) % 1440) / 60, ((tmin + 1439) % 1440) % 60, 59);
          2, 3: tm = enc(ah, am, 0);
          4:    tm = enc(ah, am, $urandom_range(1, 59));
          default: tm = enc($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
        endcase
      end
      cyc();
    end
    rst_n = 1'b1; stop = 1'b0; snooze = 1'b0;
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
